time_of_day_counter: RTL and testbench

Consumes the 1 Hz square wave from the one-second generator and maintains a BCD time-of-day (hours:minutes:seconds) for the seven-segment clock display path. All logic runs on the 100 MHz system clock; the 1 Hz signal is sampled and edge-detected, never used as a clock. Two pre-debounced set inputs advance minutes and hours. BCD digit outputs feed the display multiplexer directly.

---
 rtl/clock_pkg.sv | 36 +++
 rtl/bcd_mod_counter.sv | 66 ++++++
 rtl/time_of_day_counter.sv | 155 +++++++++++++++
 tb/tb_time_of_day_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, limits and helpers for the BCD time-of-day counter.
// Limits are plain integers; tens_of/ones_of split them into BCD digits.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HR24_MAX = 23;
    localparam int unsigned HR12_MIN = 1;
    localparam int unsigned HR12_MAX = 12;

    // Hour shown after reset: 00 in 24 h format, 12 (AM) in 12 h format.
    localparam int unsigned RST24_HR = 0;
    localparam int unsigned RST12_HR = HR12_MAX;

    localparam int unsigned EV_1HZ = 0;
    localparam int unsigned EV_MIN = 1;
    localparam int unsigned EV_HR  = 2;
    localparam int unsigned NUM_EV = 3;

    function automatic bcd_t tens_of(input int unsigned v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t ones_of(input int unsigned v);
        return bcd_t'(v % 10);
    endfunction

    // Plain two-digit BCD increment with no upper limit; callers handle wrap.
    function automatic logic [7:0] bcd_inc(input bcd_t tens, input bcd_t ones);
        if (ones == 4'd9) return {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter used for seconds and minutes.
// Priority: clear > load > inc; at_max flags the top value for carry generation.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned TENS_MAX        = 5,
    parameter int unsigned ONES_MAX_AT_TOP = 9,
    parameter int unsigned WRAP_VALUE      = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    input  logic load,
    input  bcd_t load_tens,
    input  bcd_t load_ones,
    output bcd_t tens,
    output bcd_t ones,
    output logic at_max
);

    localparam bcd_t TOP_TENS  = tens_of(TENS_MAX * 10);
    localparam bcd_t TOP_ONES  = ones_of(ONES_MAX_AT_TOP);
    localparam bcd_t WRAP_TENS = tens_of(WRAP_VALUE);
    localparam bcd_t WRAP_ONES = ones_of(WRAP_VALUE);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;

    assign at_max = (tens_q == TOP_TENS) && (ones_q == TOP_ONES);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clear) begin
            tens_d = '0;
            ones_d = '0;
        end else if (load) begin
            tens_d = load_tens;
            ones_d = load_ones;
        end else if (inc) begin
            if (at_max) begin
                tens_d = WRAP_TENS;
                ones_d = WRAP_ONES;
            end else begin
                {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time of day advanced by a sampled 1 Hz square wave plus minute/hour set inputs.
// Everything runs on clk_100MHz; the 1 Hz input is only edge-detected, never used as a clock.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter bit TWELVE_HOUR = 1'b0
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic       pm,
    output logic       sec_tick
);

    localparam bcd_t HR_RST_TENS = TWELVE_HOUR ? tens_of(RST12_HR) : tens_of(RST24_HR);
    localparam bcd_t HR_RST_ONES = TWELVE_HOUR ? ones_of(RST12_HR) : ones_of(RST24_HR);

    logic [NUM_EV-1:0] raw_in;
    logic [NUM_EV-1:0] ev;
    logic [1:0]        arm_q, arm_d;

    assign raw_in = {inc_hr, inc_min, clk_1Hz};

    // Events stay masked until s2 holds a real sample, so a level already high at release is not an edge.
    assign arm_d = {arm_q[0], 1'b1};

    for (genvar i = 0; i < NUM_EV; i++) begin : g_edge
        logic s1_q, s1_d;
        logic s2_q, s2_d;

        always_comb begin
            s1_d = raw_in[i];
            s2_d = s1_q;
        end

        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end

        assign ev[i] = s1_q & ~s2_q & arm_q[1];
    end

    logic set_ev, tick_adv, min_inc, hr_inc;
    logic sec_at_max, min_at_max;

    assign set_ev   = ev[EV_MIN] | ev[EV_HR];
    assign tick_adv = ev[EV_1HZ] & ~set_ev;
    assign min_inc  = ev[EV_MIN] | (tick_adv & sec_at_max);
    assign hr_inc   = ev[EV_HR]  | (tick_adv & sec_at_max & min_at_max);

    bcd_mod_counter #(
        .TENS_MAX       (SEC_MAX / 10),
        .ONES_MAX_AT_TOP(SEC_MAX % 10),
        .WRAP_VALUE     (0)
    ) u_sec (
        .clk      (clk_100MHz),
        .reset    (reset),
        .inc      (tick_adv),
        .clear    (set_ev),
        .load     (1'b0),
        .load_tens('0),
        .load_ones('0),
        .tens     (sec_tens),
        .ones     (sec_ones),
        .at_max   (sec_at_max)
    );

    bcd_mod_counter #(
        .TENS_MAX       (MIN_MAX / 10),
        .ONES_MAX_AT_TOP(MIN_MAX % 10),
        .WRAP_VALUE     (0)
    ) u_min (
        .clk      (clk_100MHz),
        .reset    (reset),
        .inc      (min_inc),
        .clear    (1'b0),
        .load     (1'b0),
        .load_tens('0),
        .load_ones('0),
        .tens     (min_tens),
        .ones     (min_ones),
        .at_max   (min_at_max)
    );

    bcd_t hr_tens_q, hr_tens_d;
    bcd_t hr_ones_q, hr_ones_d;
    logic pm_q, pm_d;
    logic sec_tick_q, sec_tick_d;

    always_comb begin
        hr_tens_d  = hr_tens_q;
        hr_ones_d  = hr_ones_q;
        pm_d       = pm_q;
        sec_tick_d = tick_adv;
        if (hr_inc) begin
            if (TWELVE_HOUR) begin
                if (hr_tens_q == tens_of(HR12_MAX) && hr_ones_q == ones_of(HR12_MAX)) begin
                    hr_tens_d = tens_of(HR12_MIN);
                    hr_ones_d = ones_of(HR12_MIN);
                end else if (hr_tens_q == tens_of(HR12_MAX - 1) &&
                             hr_ones_q == ones_of(HR12_MAX - 1)) begin
                    // 11 -> 12 is the only step that crosses noon or midnight.
                    hr_tens_d = tens_of(HR12_MAX);
                    hr_ones_d = ones_of(HR12_MAX);
                    pm_d      = ~pm_q;
                end else begin
                    {hr_tens_d, hr_ones_d} = bcd_inc(hr_tens_q, hr_ones_q);
                end
            end else begin
                if (hr_tens_q == tens_of(HR24_MAX) && hr_ones_q == ones_of(HR24_MAX)) begin
                    hr_tens_d = '0;
                    hr_ones_d = '0;
                end else begin
                    {hr_tens_d, hr_ones_d} = bcd_inc(hr_tens_q, hr_ones_q);
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            arm_q      <= 2'b00;
            hr_tens_q  <= HR_RST_TENS;
            hr_ones_q  <= HR_RST_ONES;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            arm_q      <= arm_d;
            hr_tens_q  <= hr_tens_d;
            hr_ones_q  <= hr_ones_d;
            pm_q       <= pm_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign hr_tens  = hr_tens_q;
    assign hr_ones  = hr_ones_q;
    assign pm       = pm_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: a 24 h and a 12 h instance share the same stimulus.
// Times are compared as 24-bit hhmmss words, which read as plain hex thanks to BCD.
module tb_time_of_day_counter;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    logic clk_1Hz    = 1'b0;
    logic inc_min    = 1'b0;
    logic inc_hr     = 1'b0;

    logic [3:0] s1_24, s10_24, m1_24, m10_24, h1_24, h10_24;
    logic [3:0] s1_12, s10_12, m1_12, m10_12, h1_12, h10_12;
    logic       pm24, pm12, tick24, tick12;
    logic [23:0] t24, t12;

    int checks = 0;
    int passed = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    time_of_day_counter #(.TWELVE_HOUR(1'b0)) dut24 (
        .clk_100MHz(clk_100MHz), .reset(reset), .clk_1Hz(clk_1Hz),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .sec_ones(s1_24), .sec_tens(s10_24), .min_ones(m1_24), .min_tens(m10_24),
        .hr_ones(h1_24), .hr_tens(h10_24), .pm(pm24), .sec_tick(tick24)
    );

    time_of_day_counter #(.TWELVE_HOUR(1'b1)) dut12 (
        .clk_100MHz(clk_100MHz), .reset(reset), .clk_1Hz(clk_1Hz),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .sec_ones(s1_12), .sec_tens(s10_12), .min_ones(m1_12), .min_tens(m10_12),
        .hr_ones(h1_12), .hr_tens(h10_12), .pm(pm12), .sec_tick(tick12)
    );

    assign t24 = {h10_24, h1_24, m10_24, m1_24, s10_24, s1_24};
    assign t12 = {h10_12, h1_12, m10_12, m1_12, s10_12, s1_12};

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    // One rising edge on the selected inputs: high for 3 cycles, low for 3.
    task automatic pulse(input bit p_1hz, input bit p_min, input bit p_hr);
        clk_1Hz = p_1hz;
        inc_min = p_min;
        inc_hr  = p_hr;
        step(3);
        clk_1Hz = 1'b0;
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        step(3);
    endtask

    task automatic do_reset();
        clk_1Hz = 1'b0;
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        reset   = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    task automatic preload(input int hrs, input int mins, input int secs);
        repeat (hrs)  pulse(1'b0, 1'b0, 1'b1);
        repeat (mins) pulse(1'b0, 1'b1, 1'b0);
        repeat (secs) pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int ticks_seen;
        reset   = 1'b1;
        clk_1Hz = 1'b1;
        step(3);
        reset = 1'b0;
        checks++;
        if (t24 !== 24'h000000) $display("FAIL reset_time24: got %h expected %h", t24, 24'h000000);
        else passed++;
        checks++;
        if (pm24 !== 1'b0 || tick24 !== 1'b0) $display("FAIL reset_flags24: pm=%b tick=%b expected 0 0", pm24, tick24);
        else passed++;
        checks++;
        if (t12 !== 24'h120000 || pm12 !== 1'b0) $display("FAIL reset_time12: got %h pm=%b expected 120000 pm=0", t12, pm12);
        else passed++;
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (tick24 === 1'b1) ticks_seen++;
        end
        checks++;
        if (ticks_seen !== 0 || t24 !== 24'h000000)
            $display("FAIL reset_high_1hz_no_tick: ticks=%0d time=%h expected 0 000000", ticks_seen, t24);
        else passed++;
        clk_1Hz = 1'b0;
        step(3);
    endtask

    task automatic test_basic_tick();
        clk_1Hz = 1'b1;
        step(1);
        checks++;
        if (t24 !== 24'h000000 || tick24 !== 1'b0)
            $display("FAIL tick_edge_e: time=%h tick=%b expected 000000 0", t24, tick24);
        else passed++;
        step(1);
        checks++;
        if (t24 !== 24'h000001 || tick24 !== 1'b1)
            $display("FAIL tick_edge_e1: time=%h tick=%b expected 000001 1", t24, tick24);
        else passed++;
        checks++;
        if (t12 !== 24'h120001 || tick12 !== 1'b1)
            $display("FAIL tick_edge_e1_12h: time=%h tick=%b expected 120001 1", t12, tick12);
        else passed++;
        step(1);
        checks++;
        if (t24 !== 24'h000001 || tick24 !== 1'b0)
            $display("FAIL tick_one_cycle: time=%h tick=%b expected 000001 0", t24, tick24);
        else passed++;
        clk_1Hz = 1'b0;
        step(3);
    endtask

    task automatic test_rollover();
        do_reset();
        preload(23, 59, 59);
        checks++;
        if (t24 !== 24'h235959) $display("FAIL rollover_preload: got %h expected %h", t24, 24'h235959);
        else passed++;
        checks++;
        if (t12 !== 24'h115959 || pm12 !== 1'b1)
            $display("FAIL rollover_preload_12h: got %h pm=%b expected 115959 pm=1", t12, pm12);
        else passed++;
        clk_1Hz = 1'b1;
        step(1);
        checks++;
        if (t24 !== 24'h235959) $display("FAIL rollover_before: got %h expected %h", t24, 24'h235959);
        else passed++;
        step(1);
        checks++;
        if (t24 !== 24'h000000 || tick24 !== 1'b1)
            $display("FAIL rollover_after: time=%h tick=%b expected 000000 1", t24, tick24);
        else passed++;
        checks++;
        if (t12 !== 24'h120000 || pm12 !== 1'b0)
            $display("FAIL rollover_12h: got %h pm=%b expected 120000 pm=0", t12, pm12);
        else passed++;
        clk_1Hz = 1'b0;
        step(3);
    endtask

    task automatic test_twelve_hour();
        do_reset();
        repeat (11) pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (t12 !== 24'h110000 || pm12 !== 1'b0)
            $display("FAIL hr12_eleven: got %h pm=%b expected 110000 pm=0", t12, pm12);
        else passed++;
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (t12 !== 24'h120000 || pm12 !== 1'b1)
            $display("FAIL hr12_noon: got %h pm=%b expected 120000 pm=1", t12, pm12);
        else passed++;
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (t12 !== 24'h010000 || pm12 !== 1'b1)
            $display("FAIL hr12_one_pm: got %h pm=%b expected 010000 pm=1", t12, pm12);
        else passed++;
        checks++;
        if (t24 !== 24'h130000 || pm24 !== 1'b0)
            $display("FAIL hr24_thirteen: got %h pm=%b expected 130000 pm=0", t24, pm24);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int ticks_seen;
        do_reset();
        preload(0, 5, 30);
        checks++;
        if (t24 !== 24'h000530) $display("FAIL simul_preload: got %h expected %h", t24, 24'h000530);
        else passed++;
        clk_1Hz    = 1'b1;
        inc_min    = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (tick24 === 1'b1) ticks_seen++;
        end
        checks++;
        if (t24 !== 24'h000600 || ticks_seen !== 0)
            $display("FAIL simul_tick_and_min: time=%h ticks=%0d expected 000600 0", t24, ticks_seen);
        else passed++;
        clk_1Hz = 1'b0;
        inc_min = 1'b0;
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (t24 !== 24'h000601) $display("FAIL simul_next_tick: got %h expected %h", t24, 24'h000601);
        else passed++;
    endtask

    task automatic test_back_to_back();
        inc_min = 1'b1;
        step(10);
        inc_min = 1'b0;
        step(3);
        checks++;
        if (t24 !== 24'h000700) $display("FAIL held_inc_min: got %h expected %h", t24, 24'h000700);
        else passed++;
        inc_min = 1'b1;
        inc_hr  = 1'b1;
        step(3);
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        step(3);
        checks++;
        if (t24 !== 24'h010800) $display("FAIL both_sets: got %h expected %h", t24, 24'h010800);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int ticks_seen;
        do_reset();
        preload(10, 20, 30);
        checks++;
        if (t24 !== 24'h102030) $display("FAIL midreset_preload: got %h expected %h", t24, 24'h102030);
        else passed++;
        clk_1Hz = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        checks++;
        if (t24 !== 24'h000000 || tick24 !== 1'b0)
            $display("FAIL midreset_override: time=%h tick=%b expected 000000 0", t24, tick24);
        else passed++;
        step(2);
        reset      = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (tick24 === 1'b1) ticks_seen++;
        end
        checks++;
        if (t24 !== 24'h000000 || ticks_seen !== 0)
            $display("FAIL midreset_release: time=%h ticks=%0d expected 000000 0", t24, ticks_seen);
        else passed++;
        clk_1Hz = 1'b0;
        step(3);
    endtask

    initial begin
        test_reset();
        test_basic_tick();
        test_rollover();
        test_twelve_hour();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
